// File: rtl/reg_bank_scan_compare_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_scan_compare_pkg
// Description : Shared scan FSM encoding, CMP bit positions and index-width
//               helper for the register bank / scan compare block.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_scan_compare_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    localparam int CMP_LT = 0;
    localparam int CMP_EQ = 1;
    localparam int CMP_GT = 2;

    // N is at least 2, so a one-bit index is the floor.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_scan_compare_cmp_sn_nb.sv
`default_nettype none
// ============================================================================
// Module      : cmp_sn_nb
// Description : W-bit magnitude comparator, unsigned or two's complement,
//               producing one-hot {gt, eq, lt}.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_sn_nb
    import reg_bank_scan_compare_pkg::*;
#(
    parameter int W      = 4,
    parameter int SIGNED = 0
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [2:0]   o_result
);

    logic w_lt;
    logic w_gt;

    generate
        if (SIGNED != 0) begin : g_signed
            assign w_lt = $signed(i_a) < $signed(i_b);
            assign w_gt = $signed(i_a) > $signed(i_b);
        end else begin : g_unsigned
            assign w_lt = i_a < i_b;
            assign w_gt = i_a > i_b;
        end
    endgenerate

    always_comb begin
        o_result         = 3'b000;
        o_result[CMP_LT] = w_lt;
        o_result[CMP_EQ] = (i_a == i_b);
        o_result[CMP_GT] = w_gt;
    end

endmodule
`default_nettype wire

// File: rtl/reg_bank_scan_compare.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_scan_compare
// Description : N x W register bank with registered pairwise compare and a
//               START/BUSY/DONE max/min scan engine.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_scan_compare
    import reg_bank_scan_compare_pkg::*;
#(
    parameter int W      = 4,
    parameter int N      = 4,
    parameter int SIGNED = 0,
    parameter int IW     = idx_width(N)
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic [W-1:0]  DIN,
    input  logic [N-1:0]  LD,
    input  logic [IW-1:0] SEL_A,
    input  logic [IW-1:0] SEL_B,
    input  logic          START,
    output logic [2:0]    CMP,
    output logic          BUSY,
    output logic          DONE,
    output logic [IW-1:0] MAX_IDX,
    output logic [IW-1:0] MIN_IDX,
    output logic [W-1:0]  MAX_VAL,
    output logic [W-1:0]  MIN_VAL
);

    localparam int            c_DEPTH    = 1 << IW;
    localparam logic [IW-1:0] c_LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] c_ONE_IDX  = IW'(1);

    logic [W-1:0]  regs_q [N];
    logic [W-1:0]  regs_d [N];
    logic [W-1:0]  w_rd   [c_DEPTH];

    scan_state_e   state_q,   state_d;
    logic [IW-1:0] idx_q,     idx_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic [2:0]    cmp_q,     cmp_d;
    logic [W-1:0]  max_val_q, max_val_d;
    logic [W-1:0]  min_val_q, min_val_d;
    logic [IW-1:0] max_idx_q, max_idx_d;
    logic [IW-1:0] min_idx_q, min_idx_d;

    logic [W-1:0]  w_rd_a;
    logic [W-1:0]  w_rd_b;
    logic [W-1:0]  w_scan_val;
    logic [2:0]    w_cmp_pair;
    logic [2:0]    w_cmp_max;
    logic [2:0]    w_cmp_min;
    logic          w_unused_cmp;

    // Pad the read array to a power of two so out-of-range selects read zero.
    generate
        for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_rd
            if (gi < N) begin : g_real
                assign w_rd[gi] = regs_q[gi];
            end else begin : g_pad
                assign w_rd[gi] = '0;
            end
        end
    endgenerate

    assign w_rd_a     = w_rd[SEL_A];
    assign w_rd_b     = w_rd[SEL_B];
    assign w_scan_val = w_rd[idx_q];

    cmp_sn_nb #(.W(W), .SIGNED(SIGNED)) u_cmp_pair (
        .i_a      (w_rd_a),
        .i_b      (w_rd_b),
        .o_result (w_cmp_pair)
    );

    cmp_sn_nb #(.W(W), .SIGNED(SIGNED)) u_cmp_max (
        .i_a      (w_scan_val),
        .i_b      (max_val_q),
        .o_result (w_cmp_max)
    );

    cmp_sn_nb #(.W(W), .SIGNED(SIGNED)) u_cmp_min (
        .i_a      (w_scan_val),
        .i_b      (min_val_q),
        .o_result (w_cmp_min)
    );

    // Scan updates need only strict GT / strict LT; the rest is unused.
    assign w_unused_cmp = ^{w_cmp_max[CMP_EQ], w_cmp_max[CMP_LT],
                            w_cmp_min[CMP_EQ], w_cmp_min[CMP_GT]};

    always_comb begin
        for (int i = 0; i < N; i++) begin
            regs_d[i] = regs_q[i];
            if (LD[i] && !busy_q) begin
                regs_d[i] = DIN;
            end
        end
    end

    assign cmp_d = w_cmp_pair;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        max_val_d = max_val_q;
        min_val_d = min_val_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    // Initialise from pre-load REG[0]; a same-edge load is not seen here.
                    state_d   = ST_SCAN;
                    busy_d    = 1'b1;
                    idx_d     = c_ONE_IDX;
                    max_val_d = regs_q[0];
                    min_val_d = regs_q[0];
                    max_idx_d = '0;
                    min_idx_d = '0;
                end
            end
            ST_SCAN: begin
                if (w_cmp_max[CMP_GT]) begin
                    max_val_d = w_scan_val;
                    max_idx_d = idx_q;
                end
                if (w_cmp_min[CMP_LT]) begin
                    min_val_d = w_scan_val;
                    min_idx_d = idx_q;
                end
                idx_d = idx_q + c_ONE_IDX;
                if (idx_q == c_LAST_IDX) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= '0;
            end
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cmp_q     <= 3'b000;
            max_val_q <= '0;
            min_val_q <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= regs_d[i];
            end
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cmp_q     <= cmp_d;
            max_val_q <= max_val_d;
            min_val_q <= min_val_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
        end
    end

    assign CMP     = cmp_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign MAX_IDX = max_idx_q;
    assign MIN_IDX = min_idx_q;
    assign MAX_VAL = max_val_q;
    assign MIN_VAL = min_val_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_scan_compare.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_scan_compare
// Description : Directed scoreboard bench; an unsigned and a signed instance
//               share all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_scan_compare;

    logic       CLK;
    logic       CLR;
    logic [3:0] DIN;
    logic [3:0] LD;
    logic [1:0] SEL_A;
    logic [1:0] SEL_B;
    logic       START;

    logic [2:0] cmp_u,     cmp_s;
    logic       busy_u,    busy_s;
    logic       done_u,    done_s;
    logic [1:0] max_idx_u, max_idx_s;
    logic [1:0] min_idx_u, min_idx_s;
    logic [3:0] max_val_u, max_val_s;
    logic [3:0] min_val_u, min_val_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         sgn;
        logic [2:0] cmp;
        string      tag;
    } cmp_exp_t;

    typedef struct {
        bit         sgn;
        logic [3:0] maxv;
        logic [3:0] minv;
        logic [1:0] maxi;
        logic [1:0] mini;
        string      tag;
    } scan_exp_t;

    cmp_exp_t  cmp_sbq[$];
    scan_exp_t scan_sbq[$];

    reg_bank_scan_compare #(.W(4), .N(4), .SIGNED(0)) u_dut (
        .CLK(CLK), .CLR(CLR), .DIN(DIN), .LD(LD), .SEL_A(SEL_A), .SEL_B(SEL_B),
        .START(START), .CMP(cmp_u), .BUSY(busy_u), .DONE(done_u),
        .MAX_IDX(max_idx_u), .MIN_IDX(min_idx_u), .MAX_VAL(max_val_u), .MIN_VAL(min_val_u)
    );

    reg_bank_scan_compare #(.W(4), .N(4), .SIGNED(1)) u_dut_s (
        .CLK(CLK), .CLR(CLR), .DIN(DIN), .LD(LD), .SEL_A(SEL_A), .SEL_B(SEL_B),
        .START(START), .CMP(cmp_s), .BUSY(busy_s), .DONE(done_s),
        .MAX_IDX(max_idx_s), .MIN_IDX(min_idx_s), .MAX_VAL(max_val_s), .MIN_VAL(min_val_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_cmp(input bit sgn, input logic [2:0] cmp, input string tag);
        cmp_exp_t e;
        e.sgn = sgn;
        e.cmp = cmp;
        e.tag = tag;
        cmp_sbq.push_back(e);
    endtask

    task automatic push_scan(input bit sgn, input logic [3:0] maxv, input logic [1:0] maxi,
                             input logic [3:0] minv, input logic [1:0] mini, input string tag);
        scan_exp_t e;
        e.sgn  = sgn;
        e.maxv = maxv;
        e.maxi = maxi;
        e.minv = minv;
        e.mini = mini;
        e.tag  = tag;
        scan_sbq.push_back(e);
    endtask

    // One edge, then every pending compare expectation is due.
    task automatic tick_cmp();
        cmp_exp_t e;
        tick();
        while (cmp_sbq.size() > 0) begin
            e = cmp_sbq.pop_front();
            chk(e.tag, int'(e.sgn ? cmp_s : cmp_u), int'(e.cmp));
        end
    endtask

    task automatic load(input logic [3:0] ld, input logic [3:0] din);
        LD  = ld;
        DIN = din;
        tick();
        LD  = 4'b0000;
    endtask

    // Called after the accepting edge; waits (bounded) for DONE on the unsigned instance.
    task automatic wait_done(input int exp_ticks, input string tag);
        scan_exp_t e;
        int n = 0;
        while (done_u !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (done_u !== 1'b1) chk({tag, "_busy"}, int'(busy_u), 1);
        end
        chk({tag, "_latency"}, n, exp_ticks);
        chk({tag, "_busy_at_done"}, int'(busy_u), 0);
        while (scan_sbq.size() > 0) begin
            e = scan_sbq.pop_front();
            if (e.sgn) begin
                chk({e.tag, "_done_s"}, int'(done_s), 1);
                chk({e.tag, "_max_val"}, int'(max_val_s), int'(e.maxv));
                chk({e.tag, "_max_idx"}, int'(max_idx_s), int'(e.maxi));
                chk({e.tag, "_min_val"}, int'(min_val_s), int'(e.minv));
                chk({e.tag, "_min_idx"}, int'(min_idx_s), int'(e.mini));
            end else begin
                chk({e.tag, "_max_val"}, int'(max_val_u), int'(e.maxv));
                chk({e.tag, "_max_idx"}, int'(max_idx_u), int'(e.maxi));
                chk({e.tag, "_min_val"}, int'(min_val_u), int'(e.minv));
                chk({e.tag, "_min_idx"}, int'(min_idx_u), int'(e.mini));
            end
        end
        tick();
        chk({tag, "_done_pulse_end"}, int'(done_u), 0);
    endtask

    initial begin
        CLR = 1'b1; DIN = '0; LD = '0; SEL_A = '0; SEL_B = '0; START = 1'b0;
        tick();
        tick();
        chk("rst_cmp", int'(cmp_u), 0);
        chk("rst_busy", int'(busy_u), 0);
        chk("rst_done", int'(done_u), 0);
        chk("rst_max_val", int'(max_val_u), 0);
        chk("rst_min_val", int'(min_val_u), 0);
        chk("rst_max_idx", int'(max_idx_u), 0);
        chk("rst_min_idx", int'(min_idx_u), 0);
        CLR = 1'b0;

        push_cmp(0, 3'b010, "post_rst_eq");
        tick_cmp();

        // Unsigned contents 3, 9, 9, 1
        load(4'b0001, 4'd3);
        load(4'b0010, 4'd9);
        load(4'b0100, 4'd9);
        load(4'b1000, 4'd1);
        SEL_A = 2'd0; SEL_B = 2'd1; push_cmp(0, 3'b001, "cmp_0_1_lt"); tick_cmp();
        SEL_A = 2'd1; SEL_B = 2'd2; push_cmp(0, 3'b010, "cmp_1_2_eq"); tick_cmp();
        SEL_A = 2'd1; SEL_B = 2'd3; push_cmp(0, 3'b100, "cmp_1_3_gt"); tick_cmp();

        push_scan(0, 4'd9, 2'd1, 4'd1, 2'd3, "scan_basic");
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("scan_basic_busy_k", int'(busy_u), 1);
        chk("scan_basic_done_k", int'(done_u), 0);
        wait_done(3, "scan_basic");
        chk("scan_basic_hold_max", int'(max_val_u), 9);

        // Loads and START during BUSY must be ignored
        push_scan(0, 4'd9, 2'd1, 4'd1, 2'd3, "scan_frozen");
        START = 1'b1;
        tick();
        LD = 4'b1111; DIN = 4'd15;
        tick();
        chk("frozen_busy1", int'(busy_u), 1);
        tick();
        chk("frozen_busy2", int'(busy_u), 1);
        LD = 4'b0000; START = 1'b0;
        wait_done(1, "scan_frozen");
        SEL_A = 2'd0; SEL_B = 2'd1; push_cmp(0, 3'b001, "frozen_cmp_0_1"); tick_cmp();
        SEL_A = 2'd3; SEL_B = 2'd0; push_cmp(0, 3'b001, "frozen_cmp_3_0"); tick_cmp();
        chk("frozen_no_restart", int'(busy_u), 0);

        // All equal: ties keep index 0
        load(4'b1111, 4'd5);
        push_scan(0, 4'd5, 2'd0, 4'd5, 2'd0, "scan_tie");
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_done(3, "scan_tie");

        // Same-edge load and START: init sees pre-load REG0 (5), REG1 sees 2
        push_scan(0, 4'd5, 2'd0, 4'd2, 2'd1, "scan_ld_start");
        LD = 4'b0011; DIN = 4'd2; START = 1'b1;
        tick();
        LD = 4'b0000; START = 1'b0;
        wait_done(3, "scan_ld_start");

        // Contents 8, 7, 0, 0: signed -8 < 7, unsigned 8 > 7
        load(4'b0001, 4'b1000);
        load(4'b0010, 4'b0111);
        load(4'b1100, 4'b0000);
        SEL_A = 2'd0; SEL_B = 2'd1;
        push_cmp(1, 3'b001, "s_cmp_neg8_7");
        push_cmp(0, 3'b100, "u_cmp_8_7");
        tick_cmp();
        push_scan(1, 4'b0111, 2'd1, 4'b1000, 2'd0, "s_scan");
        push_scan(0, 4'd8, 2'd0, 4'd0, 2'd2, "u_scan");
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_done(3, "scan_mixed");

        // Asynchronous reset mid-scan
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        chk("clr_pre_busy", int'(busy_u), 1);
        #2 CLR = 1'b1;
        #1;
        chk("clr_busy", int'(busy_u), 0);
        chk("clr_done", int'(done_u), 0);
        chk("clr_cmp", int'(cmp_u), 0);
        chk("clr_max_val", int'(max_val_u), 0);
        chk("clr_min_val", int'(min_val_u), 0);
        chk("clr_max_idx", int'(max_idx_u), 0);
        chk("clr_min_idx", int'(min_idx_u), 0);
        chk("clr_busy_s", int'(busy_s), 0);
        chk("clr_max_val_s", int'(max_val_s), 0);
        tick();
        CLR = 1'b0;
        SEL_A = 2'd0; SEL_B = 2'd1;
        push_cmp(0, 3'b010, "clr_regs_zero_u");
        push_cmp(1, 3'b010, "clr_regs_zero_s");
        tick_cmp();
        for (int i = 0; i < 5; i++) begin
            chk("clr_no_done", int'(done_u), 0);
            chk("clr_no_busy", int'(busy_u), 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
